piso_shifter: RTL and testbench
===============================

PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter WIDTH, default 4: number of bits per frame.
REQ-002 Parameter TIME, default 26'd50000000: clk cycles each serial bit is held; legal range 1 to 2^CNT_W.
REQ-003 Parameter CNT_W, default 26: width of the bit-period counter.
REQ-004 Port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port load, input, 1: request to start a frame; sampled on the rising edge of clk.
REQ-007 Port din, input, WIDTH: parallel word; captured on an accepted load.
REQ-008 Port ready, output, 1: high when the block can accept load.
REQ-009 Port busy, output, 1: high while a frame is being shifted out.
REQ-010 Port out, output, 1: serial data, MSB first.
REQ-011 Port done, output, 1: one-clk pulse marking the end of a frame.

Function
REQ-012 The block SHALL implement two states, IDLE and SHIFT.
REQ-013 ready SHALL be high exactly when the state is IDLE; busy SHALL be its complement; both SHALL be registered.
REQ-014 A load SHALL be accepted only on an edge where load=1 and the state is IDLE.
REQ-015 On an accept edge, the block SHALL:
  - capture din into an internal shift register;
  - drive out to din[WIDTH-1];
  - clear the period counter and bit index to 0;
  - enter SHIFT.
REQ-016 In SHIFT, the period counter SHALL increment each clk and wrap to 0 when it equals TIME-1 (the bit-end edge).
REQ-017 At a bit-end edge with bit index < WIDTH-1:
  - the shift register SHALL shift left by one;
  - out SHALL take the next lower bit;
  - the bit index SHALL increment.
REQ-018 At a bit-end edge with bit index = WIDTH-1:
  - the state SHALL return to IDLE;
  - out SHALL return to 0;
  - done SHALL be 1 for exactly the following clk cycle.
REQ-019 Each bit SHALL be held on out for exactly TIME clk cycles; a frame SHALL last WIDTH*TIME cycles from the accept edge to the edge that raises done.
REQ-020 load asserted in SHIFT SHALL be ignored and SHALL NOT alter the shift register, counter, bit index or out.
REQ-021 load asserted in the cycle where done=1 SHALL be accepted, giving one idle cycle between frames.
REQ-022 Changes on din outside an accept edge SHALL have no effect.
REQ-023 With TIME=1, each bit SHALL last one cycle and the period counter SHALL stay at 0.
REQ-024 In IDLE, out SHALL be 0 and the period counter SHALL be held at 0.

Reset
REQ-025 While rst=0, the block SHALL asynchronously enter IDLE with out=0, done=0, busy=0, ready=1, shift register=0, period counter=0 and bit index=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame without a done pulse.
REQ-027 After rst deasserts, the first accepted load SHALL start a complete, fresh frame.

Verification (WIDTH=4, TIME=4 unless stated)
REQ-028 Basic frame:
  - stimulus: load=1 for one cycle with din=4'b1011;
  - response: out=1,0,1,1, each bit for 4 cycles;
  - response: done pulses once, 16 cycles after the accept edge;
  - response: out=0 and ready=1 afterwards.
REQ-029 Ignored load:
  - stimulus: during the frame of REQ-028, load=1 with din=4'b0000 at cycle 6;
  - response: serial output and timing are unchanged.
REQ-030 Back-to-back:
  - stimulus: load din=4'b1100, then load din=4'b0011 in the done cycle;
  - response: out=1,1,0,0, then one idle cycle with out=0, then 0,0,1,1;
  - response: two done pulses, 17 cycles apart.
REQ-031 Reset mid-frame:
  - stimulus: rst=0 asynchronously at cycle 9 of a frame with din=4'b1111;
  - response: out=0 and ready=1 immediately; no done pulse;
  - stimulus: next load with din=4'b1000;
  - response: out=1,0,0,0.
REQ-032 TIME=1:
  - stimulus: load din=4'b0110;
  - response: out=0,1,1,0 on consecutive cycles; done pulses 4 cycles after the accept edge.

Source files
------------

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in / serial-out shifter.
// A frame captures a WIDTH-bit word on an accepted load and shifts it out MSB
// first, holding each bit for TIME clk cycles. done pulses for one cycle after
// the last bit, and the block is ready for a new load in that same cycle.
module piso_shifter #(
   parameter int WIDTH = 4,
   parameter     TIME  = 26'd50000000,
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             busy,
   output logic             out,
   output logic             done
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sreg, sreg_nxt, sreg_sh;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic               out_nxt, done_nxt, ready_nxt;
   logic               accept, bit_end, last_bit;

   assign accept   = load && (state == IDLE);
   assign bit_end  = (state == SHIFT) && (cnt == CNT_LAST);
   assign last_bit = (idx == IDX_LAST);
   // Shifted copy used both as the next register value and to pick the next bit.
   assign sreg_sh  = sreg << 1;

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state: leave IDLE on accept, return after the last bit period ends.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (bit_end && last_bit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath next values; load in SHIFT falls through untouched.
   always_comb begin
      sreg_nxt  = sreg;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      out_nxt   = out;
      done_nxt  = 1'b0;
      ready_nxt = (state_nxt == IDLE);
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            out_nxt = 1'b0;
            if (accept) begin
               sreg_nxt = din;
               out_nxt  = din[WIDTH-1];
            end
         end
         SHIFT: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (last_bit) begin
                  out_nxt  = 1'b0;
                  done_nxt = 1'b1;
               end else begin
                  sreg_nxt = sreg_sh;
                  out_nxt  = sreg_sh[WIDTH-1];
                  idx_nxt  = idx + IDX_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg  <= '0;
         cnt   <= '0;
         idx   <= '0;
         out   <= 1'b0;
         done  <= 1'b0;
         ready <= 1'b1;
         busy  <= 1'b0;
      end else begin
         sreg  <= sreg_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         out   <= out_nxt;
         done  <= done_nxt;
         ready <= ready_nxt;
         busy  <= ~ready_nxt;
      end
   end

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: two shifters (TIME=4 and TIME=1) share clk/rst/load/din and
// are checked every cycle against a frame-timeline model: a frame is just a
// start cycle plus the captured word, and the expected serial bit is derived
// from the elapsed time since that start.
module tb_piso_shifter;

   localparam int W  = 4;
   localparam int T0 = 4;
   localparam int T1 = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] din = '0;
   logic         ready0, busy0, out0, done0;
   logic         ready1, busy1, out1, done1;

   always #5 clk = ~clk;

   piso_shifter #(.WIDTH(W), .TIME(T0), .CNT_W(26)) dut0 (
      .clk(clk), .rst(rst), .load(load), .din(din),
      .ready(ready0), .busy(busy0), .out(out0), .done(done0)
   );

   piso_shifter #(.WIDTH(W), .TIME(T1), .CNT_W(26)) dut1 (
      .clk(clk), .rst(rst), .load(load), .din(din),
      .ready(ready1), .busy(busy1), .out(out1), .done(done1)
   );

   int           cyc = 0;
   int           n_cmp = 0;
   int           n_err = 0;
   int           start[2];
   logic [W-1:0] data[2];
   int           tper[2];
   int           prev_done0 = 0;
   int           last_done0 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // A frame occupies cycles start .. start+W*T-1 (sampled after each edge).
   function automatic bit in_frame(input int i, input int t);
      return (t >= start[i]) && (t < start[i] + W * tper[i]);
   endfunction

   function automatic logic exp_out(input int i);
      int b;
      if (!in_frame(i, cyc)) return 1'b0;
      b = W - 1 - (cyc - start[i]) / tper[i];
      return data[i][b];
   endfunction

   function automatic logic exp_done(input int i);
      return cyc == start[i] + W * tper[i];
   endfunction

   task automatic check_all();
      chk("out0",   32'(out0),   32'(exp_out(0)));
      chk("done0",  32'(done0),  32'(exp_done(0)));
      chk("ready0", 32'(ready0), 32'(!in_frame(0, cyc)));
      chk("busy0",  32'(busy0),  32'(in_frame(0, cyc)));
      chk("out1",   32'(out1),   32'(exp_out(1)));
      chk("done1",  32'(done1),  32'(exp_done(1)));
      chk("ready1", 32'(ready1), 32'(!in_frame(1, cyc)));
      chk("busy1",  32'(busy1),  32'(in_frame(1, cyc)));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out0"},   32'(out0),   32'd0);
      chk({tag, "_done0"},  32'(done0),  32'd0);
      chk({tag, "_ready0"}, 32'(ready0), 32'd1);
      chk({tag, "_busy0"},  32'(busy0),  32'd0);
      chk({tag, "_out1"},   32'(out1),   32'd0);
      chk({tag, "_ready1"}, 32'(ready1), 32'd1);
   endtask

   // One clock: the model accepts a load only if it was idle before this edge.
   task automatic step();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++)
         if (load && !in_frame(i, cyc - 1)) begin
            start[i] = cyc;
            data[i]  = din;
         end
      #1;
      check_all();
      if (done0) begin
         prev_done0 = last_done0;
         last_done0 = cyc;
      end
   endtask

   task automatic drive(input logic l, input logic [W-1:0] d);
      load = l;
      din  = d;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      #1 rst = 1'b0;
      #1 check_reset_state("async_rst");
      start[0] = -1000;
      start[1] = -1000;
      #1 rst = 1'b1;
   endtask

   initial begin
      start[0] = -1000;
      start[1] = -1000;
      tper[0]  = T0;
      tper[1]  = T1;
      #8 check_reset_state("por");
      #4 rst = 1'b1;

      // Basic frame 1011, with an ignored load of 0000 six cycles in.
      drive(1'b1, 4'b1011); step();
      drive(1'b0, 4'b0101); repeat (5) step();
      drive(1'b1, 4'b0000); step();
      drive(1'b0, 4'b1110); repeat (12) step();

      // Back-to-back: second load lands in the done cycle of the first.
      drive(1'b1, 4'b1100); step();
      drive(1'b0, 4'b0000); repeat (16) step();
      drive(1'b1, 4'b0011); step();
      drive(1'b0, 4'b0000); repeat (17) step();
      chk("b2b_gap", 32'(last_done0 - prev_done0), 32'd17);

      // Reset mid-frame, then a fresh frame.
      drive(1'b1, 4'b1111); step();
      drive(1'b0, 4'b0000); repeat (8) step();
      do_reset();
      repeat (20) step();
      drive(1'b1, 4'b1000); step();
      drive(1'b0, 4'b0000); repeat (18) step();

      // Randomized loads, data churn and occasional resets.
      repeat (3000) begin
         drive(1'($urandom_range(0, 3) == 0), W'($urandom));
         step();
         if ($urandom_range(0, 249) == 0) do_reset();
      end
      drive(1'b0, 4'b0000);
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
